// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - 640x480@60 VGA scanout of a 160x120 3-bit framebuffer
// Pixel ticks run at half of CLOCK_50; colour, blank and sync share a two-tick pipeline to the pins.
module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int FB_WIDTH  = 160
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic [14:0] rd_addr,
  input  logic [2:0]  rd_data,
  output logic        frame_start,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [14:0] ROW_STRIDE = 15'(FB_WIDTH);

  logic       phase;
  logic [9:0] h_count;
  logic [9:0] v_count;

  logic       h_wrap;
  logic       v_wrap;
  logic       visible;
  logic       hs_n;
  logic       vs_n;
  logic [7:0] fb_x;
  logic [6:0] fb_y;
  logic [14:0] addr_next;

  logic       s1_visible;
  logic       s1_hs_n;
  logic       s1_vs_n;

  assign VGA_CLK    = phase;
  assign VGA_SYNC_N = 1'b0;

  always_comb begin
    h_wrap  = (h_count == H_LAST);
    v_wrap  = (v_count == V_LAST);
    visible = (h_count < H_VIS_END) && (v_count < V_VIS_END);
    hs_n    = !((h_count >= HS_START) && (h_count < HS_END));
    vs_n    = !((v_count >= VS_START) && (v_count < VS_END));
    // Each framebuffer pixel covers a 4x4 block of screen pixels.
    fb_x      = h_count[9:2];
    fb_y      = v_count[8:2];
    addr_next = 15'(fb_y) * ROW_STRIDE + 15'(fb_x);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      phase       <= 1'b0;
      h_count     <= '0;
      v_count     <= '0;
      rd_addr     <= '0;
      frame_start <= 1'b0;
      s1_visible  <= 1'b0;
      s1_hs_n     <= 1'b1;
      s1_vs_n     <= 1'b1;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      phase       <= ~phase;
      frame_start <= 1'b0;
      if (phase) begin
        h_count <= h_wrap ? 10'd0 : h_count + 10'd1;
        if (h_wrap) begin
          v_count <= v_wrap ? 10'd0 : v_count + 10'd1;
        end
        frame_start <= h_wrap && v_wrap;

        rd_addr    <= visible ? addr_next : 15'd0;
        s1_visible <= visible;
        s1_hs_n    <= hs_n;
        s1_vs_n    <= vs_n;

        // rd_data answers the address issued one tick ago, matching the stage-1 controls.
        VGA_R       <= {10{rd_data[2] & s1_visible}};
        VGA_G       <= {10{rd_data[1] & s1_visible}};
        VGA_B       <= {10{rd_data[0] & s1_visible}};
        VGA_BLANK_N <= s1_visible;
        VGA_HS      <= s1_hs_n;
        VGA_VS      <= s1_vs_n;
      end
    end
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Read side of the 160x120, 3-bit-colour pixel framebuffer: the drawing datapath writes pixels into the buffer with x/y/colour/plot, and this block reads them back out.
- Generates 640x480@60 VGA timing from CLOCK_50 using a 25 MHz pixel enable.
- Each framebuffer pixel is replicated 4x horizontally and 4x vertically.
- Reads the framebuffer through a synchronous read port with 1-clock latency and drives the board DAC pins.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixel ticks)
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BACK, 33, vertical back porch
FB_WIDTH, 160, framebuffer pixels per row (address stride)

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
rd_addr  output  15  framebuffer read address, y*FB_WIDTH + x
rd_data  input  3  framebuffer read data {R,G,B}; valid 1 clock after rd_addr
frame_start  output  1  one-clock pulse when counters wrap to (0,0)
VGA_CLK  output  1  25 MHz pixel clock
VGA_HS  output  1  horizontal sync, active low
VGA_VS  output  1  vertical sync, active low
VGA_BLANK_N  output  1  low outside visible region
VGA_SYNC_N  output  1  tied 0
VGA_R  output  10  red DAC
VGA_G  output  10  green DAC
VGA_B  output  10  blue DAC

Behaviour:
- Reset is synchronous and active-high. On reset, in the same edge:
  - phase, h_count and v_count = 0
  - rd_addr = 0, frame_start = 0
  - VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0
  - VGA_R/G/B = 0, VGA_CLK = 0
  - both pipeline stages cleared to blank/no-sync
- Reset mid-line or mid-frame restarts at (0,0); the first frame_start after reset occurs at the first wrap, not at reset.
- Clocking:
  - phase toggles every clock; VGA_CLK = phase.
  - A pixel tick is a clock with phase==1. All counter and pipeline registers update only on ticks.
- Counters:
  - h_count runs 0..H_total-1 (800), where H_total = sum of the four H parameters.
  - On h wrap, v_count advances 0..V_total-1 (525); V_total is the sum of the four V parameters.
  - Both wrap to 0 simultaneously at the end of the frame.
- Timing decode, per (h,v):
  - visible = h<640 && v<480
  - hs_n low for 656<=h<752
  - vs_n low for 490<=v<492
- Address generation (tick 0):
  - x = h_count[9:2], y = v_count[8:2]
  - rd_addr <= (y<<7) + (y<<5) + x when visible, else 0
  - Range 0..19199; no value outside that range is ever issued.
- Pipeline:
  - Stage 1 (tick 1): visible, hs_n and vs_n are delayed by one tick. rd_data is valid by this tick because the 1-clock memory latency is less than the 2-clock tick spacing.
  - Stage 2 (tick 2): outputs are registered.
    - VGA_R = {10{rd_data[2]}}, VGA_G = {10{rd_data[1]}}, VGA_B = {10{rd_data[0]}}, each gated to 0 when the delayed visible is 0.
    - VGA_BLANK_N = delayed visible; VGA_HS/VS = delayed syncs.
  - Total latency from counter value to pins: 2 pixel ticks, identical for colour, blank and sync, so the relative alignment is exact.
- frame_start:
  - High for exactly one CLOCK_50 cycle: the tick clock on which h and v wrap to 0.
  - Period is 840000 clocks.
- No backpressure. The buffer is read every tick regardless of writer activity. Simultaneous write/read hazards are owned by the dual-port RAM (read-old-data).

Test Plan:
- Assert reset 3 clocks then release -> all outputs hold their reset values during reset. The first tick is at clock 2 after release. rd_addr=0 at the first tick.
- Run 2 frames -> the frame_start interval is 840000 clocks.
  - VGA_HS low for 192 clocks per line, first falling edge 2 ticks after h_count=656.
  - VGA_VS low for 2*1600 clocks per frame.
- Model memory returning rd_data = rd_addr[2:0] -> at pins pixel (h=17,v=9) shows addr 2*160+4=324, so colour 3'b100: R=10'h3FF, G=0, B=0.
  - Pixels h=16..19 on lines v=8..11 are identical.
- rd_data forced 3'b111 throughout -> VGA_BLANK_N=0 and R/G/B=0 for h 640..799 and v 480..524; rd_addr=0 there. Colour is 3FF on all channels at (0,0) and (639,479).
- Check the corner address -> at h=639, v=479, rd_addr=19199; never greater than 19199 over a full frame.
- Assert reset at h≈300, v≈200 for 1 clock -> the next edge shows reset values and counters restart. The next frame_start comes exactly 840000 clocks after release + 2.
